// File: rtl/mmio_responder_pkg.sv
// mmio_responder_pkg: register offsets, CTRL bit positions and window decode helper
package mmio_responder_pkg;
  typedef enum logic [2:0] {
    OFF_LED, OFF_SW_LO, OFF_SW_HI, OFF_EDGE, OFF_RELOAD, OFF_COUNT, OFF_CTRL, OFF_HEX
  } reg_off_e;
  localparam int CTRL_EN = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE = 2;
  localparam int CTRL_EXP = 7;
  function automatic logic win_hit(input logic [7:0] addr, input logic [7:0] base);
    return addr[7:3] == base[7:3];
  endfunction
endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: prescaled down-counter with reload, expiry flag and interrupt
module mmio_timer import mmio_responder_pkg::*; #(
  parameter int PRESCALE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_reload,
  input  logic       wr_ctrl,
  input  logic [7:0] wdata,
  output logic [7:0] reload,
  output logic [7:0] count,
  output logic [7:0] ctrl,
  output logic       irq
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  logic [PW-1:0] pre;
  logic en, auto_rl, ie, exp, tick, expire, stop;
  assign tick = en && pre == PMAX;
  assign expire = tick && count == 8'h00;
  assign stop = !en || (wr_ctrl && !wdata[CTRL_EN]);
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      reload <= 8'h00;
      count <= 8'h00;
      en <= 1'b0;
      auto_rl <= 1'b0;
      ie <= 1'b0;
      exp <= 1'b0;
    end else begin
      pre <= (stop || wr_reload || tick) ? '0 : pre + 1'b1;
      reload <= wr_reload ? wdata : reload;
      count <= wr_reload ? wdata : !tick ? count : count != 8'h00 ? count - 8'h01 : auto_rl ? reload : count;
      // a CTRL write in the expiring cycle overrides the one-shot auto-clear of EN
      en <= wr_ctrl ? wdata[CTRL_EN] : en & ~(expire & ~auto_rl);
      auto_rl <= wr_ctrl ? wdata[CTRL_AUTO] : auto_rl;
      ie <= wr_ctrl ? wdata[CTRL_IE] : ie;
      exp <= expire | (exp & ~(wr_ctrl & wdata[CTRL_EXP]));
    end
  end
  assign ctrl = {exp, 4'b0000, ie, auto_rl, en};
  assign irq = exp & ie;
endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: 8-byte MMIO window with LED, switches, edge capture, hex latch and timer
module mmio_responder import mmio_responder_pkg::*; #(
  parameter logic [7:0] BASE = 8'hF0,
  parameter int PRESCALE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] MADDR,
  input  logic [7:0] DATA_O,
  input  logic       RD,
  input  logic       WR,
  input  logic [9:0] SW_IN,
  output logic [7:0] Q,
  output logic       SEL,
  output logic [7:0] LED,
  output logic [7:0] HEX_VAL,
  output logic       IRQ
);
  reg_off_e off;
  logic hit, wr_hit, rd_hit;
  logic [9:0] s1, s2;
  logic [7:0] s3, edges, rdata, reload, count, ctrl;
  assign off = reg_off_e'(MADDR[2:0]);
  assign hit = win_hit(MADDR, BASE);
  assign wr_hit = WR && hit;
  assign rd_hit = RD && hit;
  mmio_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk(CLK),
    .rst(RST),
    .wr_reload(wr_hit && off == OFF_RELOAD),
    .wr_ctrl(wr_hit && off == OFF_CTRL),
    .wdata(DATA_O),
    .reload(reload),
    .count(count),
    .ctrl(ctrl),
    .irq(IRQ)
  );
  always_comb begin
    rdata = 8'h00;
    case (off)
      OFF_LED:    rdata = LED;
      OFF_SW_LO:  rdata = s2[7:0];
      OFF_SW_HI:  rdata = {6'b000000, s2[9:8]};
      OFF_EDGE:   rdata = edges;
      OFF_RELOAD: rdata = reload;
      OFF_COUNT:  rdata = count;
      OFF_CTRL:   rdata = ctrl;
      OFF_HEX:    rdata = HEX_VAL;
      default:    rdata = 8'h00;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      edges <= '0;
      LED <= '0;
      HEX_VAL <= '0;
      Q <= '0;
      SEL <= 1'b0;
    end else begin
      s1 <= SW_IN;
      s2 <= s1;
      s3 <= s2[7:0];
      // new rising edges win over a same-cycle write-1-to-clear
      edges <= (s2[7:0] & ~s3) | (edges & ~((wr_hit && off == OFF_EDGE) ? DATA_O : 8'h00));
      LED <= (wr_hit && off == OFF_LED) ? DATA_O : LED;
      HEX_VAL <= (wr_hit && off == OFF_HEX) ? DATA_O : HEX_VAL;
      Q <= rd_hit ? rdata : 8'h00;
      SEL <= rd_hit;
    end
  end
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed self-checking bench for mmio_responder with PRESCALE=4
module tb_mmio_responder;
  logic CLK = 1'b0, RST = 1'b1, RD = 1'b0, WR = 1'b0, SEL, IRQ;
  logic [7:0] MADDR = 8'h00, DATA_O = 8'h00, Q, LED, HEX_VAL;
  logic [9:0] SW_IN = 10'h000;
  int pass = 0, total = 0;
  logic [7:0] rq;
  logic rs;

  mmio_responder #(.BASE(8'hF0), .PRESCALE(4)) dut (
    .CLK(CLK), .RST(RST), .MADDR(MADDR), .DATA_O(DATA_O), .RD(RD), .WR(WR),
    .SW_IN(SW_IN), .Q(Q), .SEL(SEL), .LED(LED), .HEX_VAL(HEX_VAL), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    MADDR = a;
    DATA_O = d;
    WR = 1'b1;
    cyc();
    WR = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] q, output logic s);
    MADDR = a;
    RD = 1'b1;
    cyc();
    RD = 1'b0;
    q = Q;
    s = SEL;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cyc();
    cyc();
    RST = 1'b0;
    total++; if ({Q, SEL, LED, HEX_VAL, IRQ} !== 26'h0) $display("FAIL reset_outputs got %h want 0", {Q, SEL, LED, HEX_VAL, IRQ}); else pass++;
    for (int i = 0; i < 8; i++) begin
      rd(8'hF0 + 8'(i), rq, rs);
      total++; if (rq !== 8'h00 || rs !== 1'b1) $display("FAIL reset_read%0d got q=%h sel=%b want q=00 sel=1", i, rq, rs); else pass++;
      cyc();
      total++; if (SEL !== 1'b0) $display("FAIL sel_drop%0d got %b want 0", i, SEL); else pass++;
    end
    rd(8'h10, rq, rs);
    total++; if (rq !== 8'h00 || rs !== 1'b0) $display("FAIL miss_read got q=%h sel=%b want q=00 sel=0", rq, rs); else pass++;
  endtask

  task automatic test_led_hex();
    wr(8'hF0, 8'hA5);
    total++; if (LED !== 8'hA5) $display("FAIL led_write got %h want a5", LED); else pass++;
    wr(8'hF7, 8'h3C);
    total++; if (HEX_VAL !== 8'h3C) $display("FAIL hex_write got %h want 3c", HEX_VAL); else pass++;
    rd(8'hF0, rq, rs);
    total++; if (rq !== 8'hA5 || rs !== 1'b1) $display("FAIL led_read got q=%h sel=%b want a5/1", rq, rs); else pass++;
    rd(8'hF7, rq, rs);
    total++; if (rq !== 8'h3C) $display("FAIL hex_read got %h want 3c", rq); else pass++;
    wr(8'hF1, 8'h55);
    rd(8'hF1, rq, rs);
    total++; if (rq !== 8'h00) $display("FAIL swlo_ro got %h want 00", rq); else pass++;
    wr(8'h10, 8'h77);
    total++; if (LED !== 8'hA5) $display("FAIL miss_write got %h want a5", LED); else pass++;
  endtask

  task automatic test_back_to_back();
    MADDR = 8'hF0;
    DATA_O = 8'h5A;
    RD = 1'b1;
    WR = 1'b1;
    cyc();
    RD = 1'b0;
    WR = 1'b0;
    total++; if (Q !== 8'hA5 || LED !== 8'h5A) $display("FAIL rdwr_same got q=%h led=%h want a5/5a", Q, LED); else pass++;
    rd(8'hF0, rq, rs);
    total++; if (rq !== 8'h5A) $display("FAIL rdwr_after got %h want 5a", rq); else pass++;
  endtask

  task automatic test_switch();
    SW_IN = 10'h081;
    cyc();
    rd(8'hF1, rq, rs);
    total++; if (rq !== 8'h00) $display("FAIL sw_early got %h want 00", rq); else pass++;
    rd(8'hF1, rq, rs);
    total++; if (rq !== 8'h81) $display("FAIL sw_lo got %h want 81", rq); else pass++;
    rd(8'hF3, rq, rs);
    total++; if (rq !== 8'h81) $display("FAIL edge_set got %h want 81", rq); else pass++;
    wr(8'hF3, 8'h01);
    rd(8'hF3, rq, rs);
    total++; if (rq !== 8'h80) $display("FAIL edge_w1c got %h want 80", rq); else pass++;
    SW_IN = 10'h001;
    repeat (3) cyc();
    wr(8'hF3, 8'h80);
    rd(8'hF3, rq, rs);
    total++; if (rq !== 8'h00) $display("FAIL edge_clr got %h want 00", rq); else pass++;
    SW_IN = 10'h081;
    cyc();
    cyc();
    wr(8'hF3, 8'h80);
    rd(8'hF3, rq, rs);
    total++; if (rq !== 8'h80) $display("FAIL edge_set_wins got %h want 80", rq); else pass++;
    SW_IN = 10'h381;
    repeat (3) cyc();
    rd(8'hF2, rq, rs);
    total++; if (rq !== 8'h03) $display("FAIL sw_hi got %h want 03", rq); else pass++;
  endtask

  task automatic test_timer_auto();
    logic [7:0] ec;
    wr(8'hF4, 8'h03);
    wr(8'hF6, 8'h07);
    for (int k = 1; k <= 16; k++) begin
      ec = k <= 4 ? 8'd3 : k <= 8 ? 8'd2 : k <= 12 ? 8'd1 : 8'd0;
      rd(8'hF5, rq, rs);
      total++; if (rq !== ec) $display("FAIL count_k%0d got %h want %h", k, rq, ec); else pass++;
      total++; if (IRQ !== (k == 16)) $display("FAIL irq_k%0d got %b want %b", k, IRQ, k == 16); else pass++;
    end
    rd(8'hF5, rq, rs);
    total++; if (rq !== 8'h03) $display("FAIL count_reload got %h want 03", rq); else pass++;
    rd(8'hF6, rq, rs);
    total++; if (rq !== 8'h87) $display("FAIL ctrl_exp got %h want 87", rq); else pass++;
    wr(8'hF6, 8'h80);
    total++; if (IRQ !== 1'b0) $display("FAIL irq_clear got %b want 0", IRQ); else pass++;
    rd(8'hF6, rq, rs);
    total++; if (rq !== 8'h00) $display("FAIL ctrl_clear got %h want 00", rq); else pass++;
  endtask

  task automatic test_timer_oneshot();
    wr(8'hF4, 8'h01);
    wr(8'hF6, 8'h05);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      total++; if (IRQ !== (k == 8)) $display("FAIL oneshot_irq_k%0d got %b want %b", k, IRQ, k == 8); else pass++;
    end
    rd(8'hF6, rq, rs);
    total++; if (rq !== 8'h84) $display("FAIL oneshot_ctrl got %h want 84", rq); else pass++;
    repeat (8) cyc();
    rd(8'hF5, rq, rs);
    total++; if (rq !== 8'h00) $display("FAIL oneshot_count got %h want 00", rq); else pass++;
    rd(8'hF6, rq, rs);
    total++; if (rq !== 8'h84) $display("FAIL oneshot_hold got %h want 84", rq); else pass++;
  endtask

  task automatic test_reset_mid();
    SW_IN = 10'h000;
    wr(8'hF0, 8'hFF);
    wr(8'hF4, 8'h05);
    wr(8'hF6, 8'h07);
    repeat (6) cyc();
    RST = 1'b1;
    MADDR = 8'hF7;
    DATA_O = 8'h99;
    WR = 1'b1;
    cyc();
    RST = 1'b0;
    WR = 1'b0;
    total++; if ({Q, SEL, LED, HEX_VAL, IRQ} !== 26'h0) $display("FAIL midreset_outputs got %h want 0", {Q, SEL, LED, HEX_VAL, IRQ}); else pass++;
    for (int i = 3; i < 8; i++) begin
      rd(8'hF0 + 8'(i), rq, rs);
      total++; if (rq !== 8'h00 || rs !== 1'b1) $display("FAIL midreset_read%0d got q=%h sel=%b want 00/1", i, rq, rs); else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_led_hex();
    test_back_to_back();
    test_switch();
    test_timer_auto();
    test_timer_oneshot();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
